// File: rtl/led_wave_if.sv
// Board-side signal bundle for the LED wave sequencer.
// Groups the button/switch inputs and the LED/status outputs so the
// sequencer and its environment connect through a single port.
//   Left_n, Right_n : active-low push-buttons, asynchronous to the clock
//   Sw              : speed select (0 = slow, 1 = fast)
//   Led             : registered LED drive, NUM_LED bits
//   Pos             : current wave position, zero-extended to 4 bits
//   Dir             : 1 = stepping up (left), 0 = stepping down (right)
//   Running         : 1 while the wave is moving
// Modports: master drives the inputs (board / bench), slave is the sequencer.
interface led_wave_if #(
   parameter int unsigned NUM_LED = 10
);
   logic               Left_n;
   logic               Right_n;
   logic               Sw;
   logic [NUM_LED-1:0] Led;
   logic [3:0]         Pos;
   logic               Dir;
   logic               Running;

   modport master (
      output Left_n, Right_n, Sw,
      input  Led, Pos, Dir, Running
   );

   modport slave (
      input  Left_n, Right_n, Sw,
      output Led, Pos, Dir, Running
   );
endinterface

// File: rtl/led_wave_sequencer.sv
// LED wave sequencer.
// Debounces the Left/Right buttons, runs an IDLE / RUN_L / RUN_R state machine,
// generates the step tick at the rate picked by Sw, owns the position register
// and drives every LED from a shared two-level PWM (bright at Pos, dim elsewhere).
// Ports:
//   Clk  : system clock
//   Rst  : synchronous reset, active-high
//   io   : led_wave_if.slave (Left_n, Right_n, Sw in; Led, Pos, Dir, Running out)
// Build option:
//   BOUNCE_MODE_EN defined   -> the wave ping-pongs between the end positions
//   BOUNCE_MODE_EN undefined -> the wave wraps around
module led_wave_sequencer #(
   parameter int unsigned NUM_LED      = 10,
   parameter int unsigned DEBOUNCE_CYC = 1000000,
   parameter int unsigned SLOW_DIV     = 6250000,
   parameter int unsigned FAST_DIV     = 3125000,
   parameter int unsigned PWM_PERIOD   = 500000,
   parameter int unsigned DUTY_HI      = 450000,
   parameter int unsigned DUTY_LO      = 50000
) (
   input logic        Clk,
   input logic        Rst,
   led_wave_if.slave  io
);

   localparam int unsigned StepMax = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   localparam int unsigned DbW     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned StepW   = (StepMax > 1) ? $clog2(StepMax) : 1;
   localparam int unsigned PwmW    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int unsigned PosW    = $clog2(NUM_LED);

   localparam logic [PosW-1:0] PosLast = PosW'(NUM_LED - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRunL,
      StRunR
   } state_e;

   // Index 0 = Left, index 1 = Right.
   logic [1:0]     sync1_q, sync2_q;
   logic [1:0]     db_q, db_d;
   logic [DbW-1:0] db_cnt_q [2];
   logic [DbW-1:0] db_cnt_d [2];
   logic [1:0]     press;

   logic sw_s1_q, sw_s2_q;

   state_e           state_q, state_d;
   logic             dir_q, dir_d;
   logic [StepW-1:0] step_cnt_q, step_cnt_d;
   logic [PosW-1:0]  pos_q, pos_d;
   logic [PwmW-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [NUM_LED-1:0] led_q, led_d;

   logic        left_ev, right_ev;
   logic        btn_change;
   logic        running;
   logic        tick;
   logic [31:0] div_m1;
   logic        pwm_hi, pwm_lo;

   // Debounce: count while the synced level disagrees with the accepted level.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         db_d[i]     = db_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (32'(db_cnt_q[i]) >= DEBOUNCE_CYC - 1) begin
               db_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Press event on the 1->0 transition of the debounced level.
   assign press    = db_q & ~db_d;
   assign left_ev  = press[0] & ~press[1];
   assign right_ev = press[1] & ~press[0];

   assign running = (state_q != StIdle);
   assign div_m1  = sw_s2_q ? (FAST_DIV - 1) : (SLOW_DIV - 1);

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      step_cnt_d = '0;
      pos_d      = pos_q;
      tick       = 1'b0;

      case (state_q)
         StIdle: begin
            if (left_ev) begin
               state_d = StRunL;
            end else if (right_ev) begin
               state_d = StRunR;
            end
         end
         StRunL: begin
            if (left_ev) begin
               state_d = StIdle;
            end else if (right_ev) begin
               state_d = StRunR;
            end
         end
         StRunR: begin
            if (right_ev) begin
               state_d = StIdle;
            end else if (left_ev) begin
               state_d = StRunL;
            end
         end
         default: state_d = StIdle;
      endcase

      btn_change = (state_d != state_q);

      // A button-driven state change restarts the step period; >= lets a switch
      // to the faster divisor tick at once instead of overrunning.
      if (running && !btn_change) begin
         if (32'(step_cnt_q) >= div_m1) begin
            tick = 1'b1;
         end else begin
            step_cnt_d = step_cnt_q + 1'b1;
         end
      end

      if (tick) begin
         if (state_q == StRunL) begin
`ifdef BOUNCE_MODE_EN
            if (pos_q == PosLast) begin
               pos_d   = PosLast - 1'b1;
               state_d = StRunR;
            end else begin
               pos_d = pos_q + 1'b1;
            end
`else
            pos_d = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
`endif
         end else begin
`ifdef BOUNCE_MODE_EN
            if (pos_q == '0) begin
               pos_d   = PosW'(1);
               state_d = StRunL;
            end else begin
               pos_d = pos_q - 1'b1;
            end
`else
            pos_d = (pos_q == '0) ? PosLast : pos_q - 1'b1;
`endif
         end
      end

      case (state_d)
         StRunL:  dir_d = 1'b1;
         StRunR:  dir_d = 1'b0;
         default: dir_d = dir_q;
      endcase
   end

   // Free-running PWM frame shared by all LEDs.
   always_comb begin
      pwm_cnt_d = (32'(pwm_cnt_q) >= PWM_PERIOD - 1) ? '0 : pwm_cnt_q + 1'b1;
      pwm_hi    = (32'(pwm_cnt_q) < DUTY_HI);
      pwm_lo    = (32'(pwm_cnt_q) < DUTY_LO);
      for (int unsigned i = 0; i < NUM_LED; i++) begin
         led_d[i] = (32'(pos_q) == i) ? pwm_hi : pwm_lo;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync1_q     <= 2'b11;
         sync2_q     <= 2'b11;
         db_q        <= 2'b11;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
         sw_s1_q     <= 1'b1;
         sw_s2_q     <= 1'b1;
         state_q     <= StIdle;
         dir_q       <= 1'b0;
         step_cnt_q  <= '0;
         pos_q       <= '0;
         pwm_cnt_q   <= '0;
         led_q       <= '0;
      end else begin
         sync1_q     <= {io.Right_n, io.Left_n};
         sync2_q     <= sync1_q;
         db_q        <= db_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
         sw_s1_q     <= io.Sw;
         sw_s2_q     <= sw_s1_q;
         state_q     <= state_d;
         dir_q       <= dir_d;
         step_cnt_q  <= step_cnt_d;
         pos_q       <= pos_d;
         pwm_cnt_q   <= pwm_cnt_d;
         led_q       <= led_d;
      end
   end

   assign io.Led     = led_q;
   assign io.Pos     = 4'(pos_q);
   assign io.Dir     = dir_q;
   assign io.Running = running;

endmodule

// File: tb/tb_led_wave_sequencer.sv
module tb_led_wave_sequencer;

   localparam int unsigned NLed = 10;

   logic clk;
   logic rst;
   int unsigned checks;
   int unsigned errors;
   int unsigned phase_edges;

   led_wave_if #(.NUM_LED(NLed)) bus ();

   led_wave_sequencer #(
      .NUM_LED      (NLed),
      .DEBOUNCE_CYC (4),
      .SLOW_DIV     (8),
      .FAST_DIV     (4),
      .PWM_PERIOD   (10),
      .DUTY_HI      (9),
      .DUTY_LO      (1)
   ) dut (
      .Clk (clk),
      .Rst (rst),
      .io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int unsigned wait_cyc;
      logic        left_n;
      logic        right_n;
      logic        sw;
      logic [3:0]  pos;
      logic        dir;
      logic        running;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input string n, input int unsigned w, input logic l,
                               input logic r, input logic s, input logic [3:0] p,
                               input logic d, input logic run);
      vec_t v;
      v.name = n; v.wait_cyc = w; v.left_n = l; v.right_n = r; v.sw = s;
      v.pos = p; v.dir = d; v.running = run;
      vecs.push_back(v);
   endfunction

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         phase_edges++;
      end
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Expected LED word for a frame phase with the bright LED at position p.
   function automatic logic [NLed-1:0] exp_led(input int unsigned ph, input int unsigned p);
      logic [NLed-1:0] e;
      for (int unsigned i = 0; i < NLed; i++) begin
         e[i] = (i == p) ? (ph < 9) : (ph < 1);
      end
      return e;
   endfunction

   task automatic chk_state(input string name, input logic [3:0] p, input logic d,
                            input logic run);
      chk({name, ".pos"}, 32'(bus.Pos), 32'(p));
      chk({name, ".dir"}, 32'(bus.Dir), 32'(d));
      chk({name, ".running"}, 32'(bus.Running), 32'(run));
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      phase_edges = 0;
      rst         = 1'b1;
      bus.Left_n  = 1'b1;
      bus.Right_n = 1'b1;
      bus.Sw      = 1'b0;

      // ---- reset state ----
      step(3);
      chk("reset.led", 32'(bus.Led), 32'(0));
      chk_state("reset", 4'd0, 1'b0, 1'b0);

      // ---- release: Led=0 one more cycle, then PWM frame with Pos=0 ----
      rst = 1'b0;
      phase_edges = 0;
      #3;
      chk("release.led0", 32'(bus.Led), 32'(0));
      for (int k = 0; k < 20; k++) begin
         step(1);
         chk($sformatf("release.led[%0d]", k), 32'(bus.Led),
             32'(exp_led((phase_edges - 1) % 10, 0)));
      end

      // ---- table: debounce, wrap, direction change, speed, pause, simultaneous ----
      add("glitch3",     3, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add("glitch_idle", 8, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add("db_edge5",    5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add("db_edge6",    1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
      add("first_step7", 7, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
      add("first_step8", 1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1);
      for (int k = 2; k <= 10; k++) begin
         add($sformatf("wrap%0d", k), 8, 1'b1, 1'b1, 1'b0, 4'(k % 10), 1'b1, 1'b1);
      end
      add("right_pre",   5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      add("right_ent",   1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      add("down_wrap9",  8, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1);
      add("down8",       8, 1'b1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1);
      add("midcount",    4, 1'b1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1);
      add("sw_sync",     2, 1'b1, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1);
      add("sw_imm_tick", 1, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1);
      add("fast6",       4, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1);
      add("fast5",       4, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
      add("r2l_pre",     4, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1);
      add("r2l_ent",     2, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1);
      add("up5",         4, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
      add("up6",         4, 1'b1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1);
      add("up7",         4, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
      add("pause",       2, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
      add("pause_hold", 12, 1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         bus.Left_n  = vecs[i].left_n;
         bus.Right_n = vecs[i].right_n;
         bus.Sw      = vecs[i].sw;
         step(vecs[i].wait_cyc);
         chk_state(vecs[i].name, vecs[i].pos, vecs[i].dir, vecs[i].running);
      end
      vecs.delete();

      // ---- PWM keeps running while paused at Pos=7 ----
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk($sformatf("pause.led[%0d]", k), 32'(bus.Led),
             32'(exp_led((phase_edges - 1) % 10, 7)));
      end

      // ---- simultaneous press, then IDLE->RUN_R and RUN_R->RUN_L at Pos=5 ----
      add("both_acc",    6, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
      add("both_hold",  10, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
      add("both_rel",   10, 1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
      add("idle2r",      6, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
      add("r_tick6",     4, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1);
      add("r_mid",       1, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1);
      add("r_tick5",     3, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
      add("r2l_at5",     3, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
      add("l_midstep",   2, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
      for (int i = 0; i < vecs.size(); i++) begin
         bus.Left_n  = vecs[i].left_n;
         bus.Right_n = vecs[i].right_n;
         bus.Sw      = vecs[i].sw;
         step(vecs[i].wait_cyc);
         chk_state(vecs[i].name, vecs[i].pos, vecs[i].dir, vecs[i].running);
      end

      // ---- reset mid-step in RUN_L at Pos=5 ----
      rst = 1'b1;
      step(1);
      chk("midrst.led", 32'(bus.Led), 32'(0));
      chk_state("midrst", 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      phase_edges = 0;
      step(1);
      chk("midrst.led_frame0", 32'(bus.Led), 32'(exp_led(0, 0)));

      // ---- end-of-travel at fast speed: wrap or bounce depending on build ----
      bus.Left_n = 1'b0;
      step(6);
      chk_state("end_ent", 4'd0, 1'b1, 1'b1);
      bus.Left_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step(4);
         chk(($sformatf("end_up%0d", k)), 32'(bus.Pos), 32'(k));
      end
      step(4);
`ifdef BOUNCE_MODE_EN
      chk_state("end_turn", 4'd8, 1'b0, 1'b1);
      step(4);
      chk_state("end_after", 4'd7, 1'b0, 1'b1);
`else
      chk_state("end_turn", 4'd0, 1'b1, 1'b1);
      step(4);
      chk_state("end_after", 4'd1, 1'b1, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
